// File: rtl/display_value_formatter.sv
// Seven-segment front end: hex nibble split or double-dabble BCD,
// with leading-zero blank mask and minus flag.
//
// Ports:
//   clock, reset_n       clock, async active-low reset
//   value, mode,         captured with start (mode 1 = decimal,
//   signed_mode, start   signed_mode 1 = two's complement)
//   busy, done           conversion running / one-cycle result pulse
//   digits, blank        5 x 4-bit digit codes, leading-zero mask
//   negative             minus sign for signed decimal results
module display_value_formatter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        mode,
  input  logic        signed_mode,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [19:0] digits,
  output logic [4:0]  blank,
  output logic        negative
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FINISH
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [15:0] shift;
  logic [19:0] bcd;
  logic        dec_q;
  logic        sign_q;

  logic [15:0] mag;
  logic [19:0] bcd_adj;
  logic [19:0] result;
  logic [4:0]  blank_nxt;
  logic        zero_run;

  always_comb begin
    mag = value;
    if (signed_mode && value[15])
      mag = ~value + 16'd1;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Hex mode keeps the raw value in the shift register.
  assign result = dec_q ? bcd : {4'h0, shift};

  // A digit blanks only if it and every higher digit are zero.
  always_comb begin
    blank_nxt = 5'b00000;
    zero_run  = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      zero_run     = zero_run & (result[4*i +: 4] == 4'h0);
      blank_nxt[i] = zero_run;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      shift    <= 16'd0;
      bcd      <= 20'd0;
      dec_q    <= 1'b0;
      sign_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      digits   <= 20'h00000;
      blank    <= 5'b11110;
      negative <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dec_q  <= mode;
            sign_q <= mode & signed_mode & value[15];
            shift  <= mode ? mag : value;
            bcd    <= 20'd0;
            cnt    <= 5'd16;
            busy   <= 1'b1;
            state  <= mode ? CONVERT : FINISH;
          end
        end
        CONVERT: begin
          {bcd, shift} <= {bcd_adj[18:0], shift, 1'b0};
          cnt          <= cnt - 5'd1;
          if (cnt == 5'd1)
            state <= FINISH;
        end
        FINISH: begin
          digits   <= result;
          blank    <= blank_nxt;
          negative <= dec_q & sign_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_value_formatter.sv
// Directed bench for display_value_formatter: vector table plus
// protocol, held-start and mid-conversion reset sequences.
module tb_display_value_formatter;

  logic        clock;
  logic        reset_n;
  logic [15:0] value;
  logic        mode;
  logic        signed_mode;
  logic        start;
  logic        busy;
  logic        done;
  logic [19:0] digits;
  logic [4:0]  blank;
  logic        negative;

  int total = 0;
  int bad   = 0;

  display_value_formatter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .value       (value),
    .mode        (mode),
    .signed_mode (signed_mode),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .digits      (digits),
    .blank       (blank),
    .negative    (negative)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] v;
    logic        m;
    logic        s;
    logic [19:0] dig;
    logic [4:0]  blk;
    logic        neg;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic conv(input vec_t t, input int idx);
    int n;
    @(negedge clock);
    value       = t.v;
    mode        = t.m;
    signed_mode = t.s;
    start       = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk($sformatf("v%0d busy", idx), {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk($sformatf("v%0d latency", idx), n, t.lat);
    chk($sformatf("v%0d digits", idx), {12'd0, digits}, {12'd0, t.dig});
    chk($sformatf("v%0d blank", idx), {27'd0, blank}, {27'd0, t.blk});
    chk($sformatf("v%0d neg", idx), {31'd0, negative}, {31'd0, t.neg});
    chk($sformatf("v%0d busy_end", idx), {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    chk($sformatf("v%0d done_drop", idx), {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    int done_at;

    vecs[0]  = '{16'hBEEF, 1'b0, 1'b0, 20'h0BEEF, 5'b10000, 1'b0, 1};
    vecs[1]  = '{16'd65535, 1'b1, 1'b0, 20'h65535, 5'b00000, 1'b0, 17};
    vecs[2]  = '{16'd1000, 1'b1, 1'b0, 20'h01000, 5'b10000, 1'b0, 17};
    vecs[3]  = '{16'd0, 1'b1, 1'b0, 20'h00000, 5'b11110, 1'b0, 17};
    vecs[4]  = '{16'h8000, 1'b1, 1'b1, 20'h32768, 5'b00000, 1'b1, 17};
    vecs[5]  = '{16'hFFFF, 1'b1, 1'b1, 20'h00001, 5'b11110, 1'b1, 17};
    vecs[6]  = '{16'h0012, 1'b0, 1'b1, 20'h00012, 5'b11100, 1'b0, 1};
    vecs[7]  = '{16'hFFFF, 1'b1, 1'b0, 20'h65535, 5'b00000, 1'b0, 17};
    vecs[8]  = '{16'h0000, 1'b0, 1'b0, 20'h00000, 5'b11110, 1'b0, 1};
    vecs[9]  = '{16'h7FFF, 1'b1, 1'b1, 20'h32767, 5'b00000, 1'b0, 17};
    vecs[10] = '{16'h0009, 1'b1, 1'b0, 20'h00009, 5'b11110, 1'b0, 17};
    vecs[11] = '{16'hFF85, 1'b1, 1'b1, 20'h00123, 5'b11000, 1'b1, 17};

    value       = 16'd0;
    mode        = 1'b0;
    signed_mode = 1'b0;
    start       = 1'b0;
    reset_n     = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst digits", {12'd0, digits}, 32'd0);
    chk("rst blank", {27'd0, blank}, 32'b11110);
    chk("rst neg", {31'd0, negative}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++)
      conv(vecs[i], i);

    // Start pulses during a decimal conversion must be ignored.
    @(negedge clock);
    value       = 16'd1234;
    mode        = 1'b1;
    signed_mode = 1'b0;
    start       = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    dones   = 0;
    done_at = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (c == 3 || c == 10) begin
        value = 16'd9999;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
    end
    start = 1'b0;
    chk("ign dones", dones, 1);
    chk("ign done_at", done_at, 17);
    chk("ign digits", {12'd0, digits}, 32'h01234);

    // Held start: hex restarts on every done cycle.
    @(negedge clock);
    value = 16'h0007;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clock);
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      #1;
      if (done) dones++;
      if (c == 2)
        chk("held busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clock);
    start = 1'b0;
    chk("held dones", dones, 5);
    chk("held digits", {12'd0, digits}, 32'h00007);
    repeat (3) @(posedge clock);

    // Leave negative = 1 so the mid-conversion reset has work to do.
    conv(vecs[11], 12);

    @(negedge clock);
    value       = 16'd65535;
    mode        = 1'b1;
    signed_mode = 1'b0;
    start       = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid busy", {31'd0, busy}, 32'd0);
    chk("mid done", {31'd0, done}, 32'd0);
    chk("mid digits", {12'd0, digits}, 32'd0);
    chk("mid blank", {27'd0, blank}, 32'b11110);
    chk("mid neg", {31'd0, negative}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    n = 0;
    while (n < 25) begin
      @(posedge clock);
      #1;
      if (done) dones++;
      n++;
    end
    chk("mid no_done", dones, 0);

    conv('{16'd42, 1'b1, 1'b0, 20'h00042, 5'b11100, 1'b0, 17}, 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_value_formatter.md
# display_value_formatter

Sequential front end for the seven-segment path. It captures a 16-bit value and produces per-digit 4-bit codes plus a leading-zero blank mask; each digit code feeds one hex-to-segment decoder instance. In hex mode the value is split into nibbles. In decimal mode it is converted to BCD by iterative double-dabble, optionally as a signed two's-complement number with a separate minus flag.

## Interface
Parameters: none. Width is fixed at 16 bits and the digit count at 5, enough for 65535 decimal.

Ports:
- clock  in  1  — system clock; all state updates on rising edge
- reset_n  in  1  — asynchronous, active-low reset
- value  in  16  — number to format; sampled with start
- mode  in  1  — 0 = hex, 1 = decimal; sampled with start
- signed_mode  in  1  — decimal only: 1 = treat value as two's complement; sampled with start
- start  in  1  — request conversion; honoured only while busy = 0
- busy  out  1  — conversion in progress
- done  out  1  — one-cycle pulse: new outputs valid
- digits  out  20  — digit i at bits [4i+3:4i], i = 0 least significant; each 0–15
- blank  out  5  — bit i = 1: suppress digit i (leading zero)
- negative  out  1  — 1 = display a minus sign

## Operation
- States: IDLE, CONVERT, FINISH.
- IDLE, start = 1 at an edge:
  - capture value, mode, signed_mode; busy <= 1
  - hex: state <= FINISH
  - decimal: state <= CONVERT, bit counter <= 16
- Decimal magnitude:
  - if signed_mode = 1 and value[15] = 1, the magnitude is the 16-bit unsigned two's-complement negation of value (0x8000 gives 32768); sign latched = 1
  - otherwise magnitude = value, sign latched = 0
- CONVERT, one double-dabble step per cycle:
  - every 4-bit BCD column ≥ 5 gets +3
  - then {bcd, shift} shifts left one bit
  - counter decrements; at counter 1 → 0, state <= FINISH
  - the 20-bit BCD accumulator is cleared at capture
- FINISH:
  - register the result into digits: hex gives {4'h0, value}, decimal gives the BCD accumulator
  - compute blank: bit i = 1 if and only if i ≥ 1 and digits i..4 are all zero; bit 0 is always 0
  - negative <= latched sign in decimal mode, 0 in hex mode
  - done <= 1, busy <= 0, state <= IDLE
- done is 0 in every cycle except the one following FINISH.
- Outputs hold their last result between conversions. They change only in FINISH or on reset.
- start while busy = 1 is ignored: no queuing, no restart.
- start in the cycle where done = 1 (state is IDLE) is accepted normally.
- Reset, asynchronous, at any time including mid-CONVERT:
  - state = IDLE, busy = 0, done = 0
  - digits = 20'h00000, blank = 5'b11110, negative = 0
  - counter and accumulators cleared
  - no done pulse is issued for the aborted conversion

## Timing
- Let edge k be the edge that samples start = 1 in IDLE.
- busy = 1 from edge k.
- Hex: FINISH in the cycle after edge k. digits, blank, negative and done update at edge k+1; busy = 0 at edge k+1. Latency is 1 cycle.
- Decimal: CONVERT occupies edges k+1 … k+16. FINISH acts at edge k+17: outputs, done = 1, busy = 0. Latency is 17 cycles.
- Earliest back-to-back start is the edge at which done is high, i.e. edge k+2 for hex.
- Digit and blank outputs are registered; downstream decoders are purely combinational on them.

## Test plan
- Reset: assert reset_n = 0 mid-cycle → immediately busy = 0, done = 0, digits = 0x00000, blank = 11110, negative = 0.
- Hex: value = 0xBEEF, mode = 0, start → one cycle later done = 1, digits = 0x0BEEF, blank = 10000, negative = 0; done low the following cycle.
- Unsigned decimal: value = 65535, mode = 1, signed_mode = 0 → done exactly 17 cycles after the start edge, digits = 0x65535, blank = 00000. Also value = 1000 → digits = 0x01000, blank = 10000. Also value = 0 → digits = 0x00000, blank = 11110.
- Signed decimal: value = 0x8000, signed_mode = 1 → digits = 0x32768, negative = 1. Also value = 0xFFFF → digits = 0x00001, blank = 11110, negative = 1. Also value = 0xFFFF with signed_mode = 0 → 0x65535, negative = 0.
- Protocol: start pulsed at cycles 3 and 10 of a decimal conversion → ignored, single done, result from the first value. Start held high continuously → a new conversion begins on each done cycle.
- Reset mid-conversion: assert reset_n = 0 at CONVERT step 8 → reset values, no done. After release, a new start with value 42 → digits = 0x00042, blank = 11100.
